// File: rtl/logen_cal_pkg.sv
//==============================================================================
// Module : logen_cal_pkg
// Brief  : Shared state encoding and register-field decode helpers for the
//          multi-window LOGEN LDO calibration block.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package logen_cal_pkg;

    localparam int WIN_W            = 5;
    localparam int VSEL_RST_DEFAULT = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RSTN     = 3'd1,
        ST_EN_PRE   = 3'd2,
        ST_EN       = 3'd3,
        ST_EN_POST  = 3'd4,
        ST_DATASYN  = 3'd5,
        ST_ACCUM    = 3'd6,
        ST_UPDATE   = 3'd7
    } cal_state_t;

    function automatic logic [WIN_W-1:0] win_m1_lookup(input logic [1:0] cnt_sel);
        case (cnt_sel)
            2'd0:    win_m1_lookup = 5'd7;
            2'd1:    win_m1_lookup = 5'd11;
            2'd2:    win_m1_lookup = 5'd15;
            default: win_m1_lookup = 5'd19;
        endcase
    endfunction

    function automatic logic [1:0] navg_log2_lookup(input logic [1:0] avg_sel);
        case (avg_sel)
            2'd0:    navg_log2_lookup = 2'd0;
            2'd1:    navg_log2_lookup = 2'd1;
            default: navg_log2_lookup = 2'd2;
        endcase
    endfunction

    // Index of the final measurement for a given averaging depth (2^n - 1).
    function automatic logic [1:0] meas_last_lookup(input logic [1:0] navg_log2);
        case (navg_log2)
            2'd0:    meas_last_lookup = 2'd0;
            2'd1:    meas_last_lookup = 2'd1;
            default: meas_last_lookup = 2'd3;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/logen_seg_lookup.sv
//==============================================================================
// Module : logen_seg_lookup
// Brief  : Combinational priority compare of an averaged count against
//          programmable segment upper bounds; returns segment index and vsel.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module logen_seg_lookup #(
    parameter int NSEG   = 5,
    parameter int VAL_W  = 6,
    parameter int VSEL_W = 3
) (
    input  logic [VAL_W-1:0]          val,
    input  logic [(NSEG-1)*VAL_W-1:0] bounds,
    input  logic [NSEG*VSEL_W-1:0]    segs,
    output logic [2:0]                idx,
    output logic [VSEL_W-1:0]         vsel
);

    // Walk downward so the lowest matching bound is the last one written.
    always_comb begin
        idx  = 3'(NSEG-1);
        vsel = segs[(NSEG-1)*VSEL_W +: VSEL_W];
        for (int i = NSEG-2; i >= 0; i--) begin
            if (val <= bounds[i*VAL_W +: VAL_W]) begin
                idx  = 3'(i);
                vsel = segs[i*VSEL_W +: VSEL_W];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/logen_ldo_cal_multi.sv
//==============================================================================
// Module : logen_ldo_cal_multi
// Brief  : LOGEN LDO calibration: 1/2/4 ring-counter windows, averaged and
//          mapped through programmable segments to an LDO vsel code.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module logen_ldo_cal_multi
    import logen_cal_pkg::*;
#(
    parameter int NSEG     = 5,
    parameter int CNTR_W   = 14,
    parameter int VAL_LSB  = 4,
    parameter int VAL_W    = 6,
    parameter int VSEL_W   = 3,
    parameter int VSEL_RST = VSEL_RST_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      logen_start,
    input  logic                      rg_logen_cal_bypass,
    input  logic [1:0]                rg_logen_cnt_sel,
    input  logic [1:0]                rg_logen_avg_sel,
    input  logic [VSEL_W-1:0]         rg_logen_vsel_man,
    input  logic [NSEG*VSEL_W-1:0]    rg_logen_vsel_seg,
    input  logic [(NSEG-1)*VAL_W-1:0] rg_logen_cntr_bound,
    input  logic [CNTR_W-1:0]         a2d_ncntr,
    output logic                      cntr_rstn,
    output logic                      cntr_en,
    output logic                      cntr_datasyn,
    output logic [VAL_W-1:0]          logen_cntr_curr,
    output logic [VSEL_W-1:0]         ldo_logen_vsel,
    output logic [2:0]                logen_seg_idx,
    output logic                      logen_busy,
    output logic                      logen_done
);

    cal_state_t         r_state;
    logic [2:0]         r_start_sync;
    logic [WIN_W-1:0]   r_win_m1;
    logic [WIN_W-1:0]   r_win_cnt;
    logic [1:0]         r_navg_log2;
    logic [1:0]         r_meas_cnt;
    logic [VAL_W+1:0]   r_acc;

    logic               w_start_edge;
    logic [VAL_W-1:0]   w_sample;
    logic [VAL_W-1:0]   w_avg;
    logic [2:0]         w_seg_idx;
    logic [VSEL_W-1:0]  w_seg_vsel;

    assign w_start_edge = ~r_start_sync[2] & r_start_sync[1];
    assign w_avg        = VAL_W'(r_acc >> r_navg_log2);

    // Any counter bit above the field means the count overflowed it: saturate.
    generate
        if (VAL_LSB + VAL_W < CNTR_W) begin : g_sat
            assign w_sample = (|a2d_ncntr[CNTR_W-1:VAL_LSB+VAL_W]) ? {VAL_W{1'b1}}
                                                                  : a2d_ncntr[VAL_LSB +: VAL_W];
        end else begin : g_nosat
            assign w_sample = a2d_ncntr[VAL_LSB +: VAL_W];
        end
        if (VAL_LSB > 0) begin : g_lsb_drop
            logic w_unused_lsb;
            assign w_unused_lsb = ^a2d_ncntr[VAL_LSB-1:0];
        end
    endgenerate

    logen_seg_lookup #(
        .NSEG   (NSEG),
        .VAL_W  (VAL_W),
        .VSEL_W (VSEL_W)
    ) u_seg_lookup (
        .val    (w_avg),
        .bounds (rg_logen_cntr_bound),
        .segs   (rg_logen_vsel_seg),
        .idx    (w_seg_idx),
        .vsel   (w_seg_vsel)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state         <= ST_IDLE;
            r_start_sync    <= '0;
            r_win_m1        <= '0;
            r_win_cnt       <= '0;
            r_navg_log2     <= '0;
            r_meas_cnt      <= '0;
            r_acc           <= '0;
            cntr_rstn       <= 1'b1;
            cntr_en         <= 1'b0;
            cntr_datasyn    <= 1'b0;
            logen_cntr_curr <= '0;
            ldo_logen_vsel  <= VSEL_W'(VSEL_RST);
            logen_seg_idx   <= '0;
            logen_busy      <= 1'b0;
            logen_done      <= 1'b0;
        end else begin
            r_start_sync <= {r_start_sync[1:0], logen_start};

            // Counter strobes lag the state by one cycle.
            cntr_rstn    <= (r_state != ST_RSTN);
            cntr_en      <= (r_state == ST_EN_PRE) ||
                            ((r_state == ST_EN) && (r_win_cnt != r_win_m1));
            cntr_datasyn <= (r_state == ST_EN_POST);
            logen_done   <= (r_state == ST_UPDATE);

            case (r_state)
                ST_IDLE: begin
                    if (w_start_edge) begin
                        r_win_m1    <= win_m1_lookup(rg_logen_cnt_sel);
                        r_navg_log2 <= navg_log2_lookup(rg_logen_avg_sel);
                        r_acc       <= '0;
                        r_meas_cnt  <= '0;
                        logen_busy  <= 1'b1;
                        r_state     <= ST_RSTN;
                    end
                end
                ST_RSTN: begin
                    r_state <= ST_EN_PRE;
                end
                ST_EN_PRE: begin
                    r_win_cnt <= '0;
                    r_state   <= ST_EN;
                end
                ST_EN: begin
                    if (r_win_cnt == r_win_m1) begin
                        r_state <= ST_EN_POST;
                    end else begin
                        r_win_cnt <= r_win_cnt + 1'b1;
                    end
                end
                ST_EN_POST: begin
                    r_state <= ST_DATASYN;
                end
                ST_DATASYN: begin
                    r_state <= ST_ACCUM;
                end
                ST_ACCUM: begin
                    r_acc <= r_acc + (VAL_W+2)'(w_sample);
                    if (r_meas_cnt == meas_last_lookup(r_navg_log2)) begin
                        r_state <= ST_UPDATE;
                    end else begin
                        r_meas_cnt <= r_meas_cnt + 1'b1;
                        r_state    <= ST_RSTN;
                    end
                end
                ST_UPDATE: begin
                    logen_cntr_curr <= w_avg;
                    logen_seg_idx   <= w_seg_idx;
                    if (!rg_logen_cal_bypass) begin
                        ldo_logen_vsel <= w_seg_vsel;
                    end
                    logen_busy <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    logen_busy <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase

            if (rg_logen_cal_bypass) begin
                ldo_logen_vsel <= rg_logen_vsel_man;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_logen_ldo_cal_multi.sv
//==============================================================================
// Module : tb_logen_ldo_cal_multi
// Brief  : Directed self-checking bench for logen_ldo_cal_multi.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_logen_ldo_cal_multi;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        logen_start = 1'b0;
    logic        bypass = 1'b0;
    logic [1:0]  cnt_sel = 2'd0;
    logic [1:0]  avg_sel = 2'd0;
    logic [2:0]  vsel_man = 3'd0;
    logic [14:0] vsel_seg = {3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    logic [23:0] cntr_bound = {6'd40, 6'd30, 6'd20, 6'd10};
    logic [13:0] a2d_ncntr = 14'h0;

    logic        cntr_rstn, cntr_en, cntr_datasyn;
    logic [5:0]  cntr_curr;
    logic [2:0]  vsel, seg_idx;
    logic        busy, done;

    int n_assert = 0;
    int n_fail   = 0;

    logic [13:0] sample_tab [4];
    logic [1:0]  sample_ptr = 2'd0;
    int en_total = 0, done_total = 0, ds_total = 0, rl_total = 0;
    int en_run = 0, last_en_run = 0;

    logen_ldo_cal_multi dut (
        .clk                 (clk),
        .rstn                (rstn),
        .logen_start         (logen_start),
        .rg_logen_cal_bypass (bypass),
        .rg_logen_cnt_sel    (cnt_sel),
        .rg_logen_avg_sel    (avg_sel),
        .rg_logen_vsel_man   (vsel_man),
        .rg_logen_vsel_seg   (vsel_seg),
        .rg_logen_cntr_bound (cntr_bound),
        .a2d_ncntr           (a2d_ncntr),
        .cntr_rstn           (cntr_rstn),
        .cntr_en             (cntr_en),
        .cntr_datasyn        (cntr_datasyn),
        .logen_cntr_curr     (cntr_curr),
        .ldo_logen_vsel      (vsel),
        .logen_seg_idx       (seg_idx),
        .logen_busy          (busy),
        .logen_done          (done)
    );

    always #5 clk = ~clk;

    // Analog counter stand-in: presents the next sample while datasyn is high.
    always @(negedge clk) begin
        if (cntr_datasyn) begin
            a2d_ncntr  = sample_tab[sample_ptr];
            sample_ptr = sample_ptr + 2'd1;
            ds_total   = ds_total + 1;
        end
        if (cntr_en) begin
            en_total = en_total + 1;
            en_run   = en_run + 1;
        end else if (en_run != 0) begin
            last_en_run = en_run;
            en_run      = 0;
        end
        if (!cntr_rstn) rl_total = rl_total + 1;
        if (done)       done_total = done_total + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_all(input logic [13:0] v);
        for (int i = 0; i < 4; i++) sample_tab[i] = v;
    endtask

    // Cycles from raising start (one posedge+2 step each) until done is seen; 0 on timeout.
    task automatic run_cal(input int max_cyc, output int lat, output logic busy_mid,
                           output logic [2:0] vsel_mid);
        lat = 0;
        busy_mid = 1'b0;
        vsel_mid = 3'd0;
        logen_start = 1'b1;
        for (int c = 1; c <= max_cyc; c++) begin
            tick();
            if (c == 5) logen_start = 1'b0;
            if (c == 8) begin
                busy_mid = busy;
                vsel_mid = vsel;
            end
            if (done === 1'b1) begin
                lat = c;
                break;
            end
        end
        logen_start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output int lat);
        lat = 0;
        for (int c = 1; c <= max_cyc; c++) begin
            tick();
            if (done === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    int         lat;
    logic       bm;
    logic [2:0] vm;
    int         en0, ds0, rl0, d0;

    initial begin
        set_all(14'h0150);

        // Reset state
        tick(3);
        check("rst_cntr_rstn", cntr_rstn, 1);
        check("rst_cntr_en", cntr_en, 0);
        check("rst_datasyn", cntr_datasyn, 0);
        check("rst_curr", cntr_curr, 0);
        check("rst_vsel", vsel, 2);
        check("rst_seg_idx", seg_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rstn = 1'b1;
        tick(3);

        // Single 8-cycle window, count 21 -> segment 2
        d0 = done_total;
        run_cal(60, lat, bm, vm);
        check("a_latency", lat, 17);
        check("a_busy_mid", bm, 1);
        check("a_busy_end", busy, 0);
        check("a_curr", cntr_curr, 21);
        check("a_seg_idx", seg_idx, 2);
        check("a_vsel", vsel, 2);
        check("a_en_window", last_en_run, 8);
        tick();
        check("a_done_pulse_width", done, 0);
        check("a_done_count", done_total - d0, 1);

        // Four windows, samples 16..19 -> acc 70, avg 17 -> segment 1
        tick(4);
        sample_tab[0] = 14'h0100;
        sample_tab[1] = 14'h0110;
        sample_tab[2] = 14'h0120;
        sample_tab[3] = 14'h0130;
        avg_sel = 2'd2;
        en0 = en_total; ds0 = ds_total; rl0 = rl_total;
        run_cal(120, lat, bm, vm);
        check("b_latency", lat, 56);
        check("b_curr", cntr_curr, 17);
        check("b_seg_idx", seg_idx, 1);
        check("b_vsel", vsel, 1);
        tick();
        check("b_en_cycles", en_total - en0, 32);
        check("b_datasyn_pulses", ds_total - ds0, 4);
        check("b_cntr_rstn_lows", rl_total - rl0, 4);
        check("b_en_window", last_en_run, 8);

        // Overflow above the field saturates to 63 -> last segment
        tick(4);
        avg_sel = 2'd0;
        set_all(14'h0800);
        run_cal(60, lat, bm, vm);
        check("c_latency", lat, 17);
        check("c_curr", cntr_curr, 63);
        check("c_seg_idx", seg_idx, 4);
        check("c_vsel", vsel, 4);

        // Bypass: vsel follows manual code, calibration still updates curr/seg
        tick(4);
        set_all(14'h0150);
        bypass = 1'b1;
        vsel_man = 3'd5;
        tick();
        check("byp_vsel_immediate", vsel, 5);
        run_cal(60, lat, bm, vm);
        check("byp_vsel_mid", vm, 5);
        check("byp_latency", lat, 17);
        check("byp_vsel_end", vsel, 5);
        check("byp_curr", cntr_curr, 21);
        check("byp_seg_idx", seg_idx, 2);
        bypass = 1'b0;
        tick(2);
        check("byp_off_vsel_hold", vsel, 5);

        // Second start edge while busy is dropped
        tick(4);
        set_all(14'h0100);
        d0 = done_total;
        logen_start = 1'b1;
        tick(5);
        logen_start = 1'b0;
        tick(3);
        logen_start = 1'b1;
        tick(3);
        logen_start = 1'b0;
        wait_done(40, lat);
        check("drop_done_seen", (lat > 0) ? 1 : 0, 1);
        tick(30);
        check("drop_done_count", done_total - d0, 1);
        check("drop_busy", busy, 0);
        check("drop_curr", cntr_curr, 16);

        // Reset during the enable window
        tick(4);
        set_all(14'h0150);
        d0 = done_total;
        logen_start = 1'b1;
        tick(8);
        check("rsten_en_active", cntr_en, 1);
        rstn = 1'b0;
        logen_start = 1'b0;
        tick();
        check("rsten_vsel", vsel, 2);
        check("rsten_curr", cntr_curr, 0);
        check("rsten_seg_idx", seg_idx, 0);
        check("rsten_busy", busy, 0);
        check("rsten_cntr_en", cntr_en, 0);
        rstn = 1'b1;
        tick(30);
        check("rsten_no_done", done_total - d0, 0);
        check("rsten_busy_after", busy, 0);

        // cnt_sel change mid-run is ignored; next run uses 20-cycle window
        cnt_sel = 2'd0;
        logen_start = 1'b1;
        tick(5);
        logen_start = 1'b0;
        cnt_sel = 2'd3;
        wait_done(60, lat);
        check("win_chg_latency", lat, 12);
        check("win_chg_window", last_en_run, 8);
        tick(4);
        run_cal(80, lat, bm, vm);
        check("win20_latency", lat, 29);
        check("win20_window", last_en_run, 20);
        check("win20_curr", cntr_curr, 21);
        check("win20_vsel", vsel, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
